// File: rtl/seq_adder_nbit.sv
// Multi-cycle adder/subtractor: adds WIDTH-bit operands CHUNK bits per clock.
// The carry ripples through a register between chunks, under a start/busy/done handshake.
module seq_adder_nbit #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_in,
   output logic [WIDTH-1:0] S,
   output logic             C_out,
   output logic             V,
   output logic             busy,
   output logic             done
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned CntW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(NCHUNK - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             carry_q, carry_d;
   logic             c_out_q, c_out_d;
   logic             v_q, v_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   logic [31:0]      shamt;
   logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
   logic             chunk_c;

   // Single shared CHUNK-bit adder slice, indexed by the chunk counter.
   always_comb begin
      shamt     = 32'(cnt_q) * CHUNK;
      a_chunk   = CHUNK'(a_q >> shamt);
      b_chunk   = CHUNK'(b_q >> shamt);
      {chunk_c, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK + 1)'(carry_q);
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      carry_d = carry_q;
      c_out_d = c_out_q;
      v_d     = v_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (start) begin
               a_d     = A;
               b_d     = sub ? ~B : B;
               carry_d = sub ? 1'b1 : C_in;
               cnt_d   = '0;
               s_d     = '0;
               c_out_d = 1'b0;
               v_d     = 1'b0;
               state_d = StRun;
            end
         end
         StRun: begin
            // Upper chunks of S are still zero, so OR-ing in the new chunk is enough.
            s_d     = s_q | (WIDTH'(sum_chunk) << shamt);
            carry_d = chunk_c;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               c_out_d = chunk_c;
               v_d     = (a_chunk[CHUNK-1] == b_chunk[CHUNK-1]) &&
                         (sum_chunk[CHUNK-1] != a_chunk[CHUNK-1]);
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         v_q     <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         c_out_q <= c_out_d;
         v_q     <= v_d;
         cnt_q   <= cnt_d;
      end
   end

   assign S     = s_q;
   assign C_out = c_out_q;
   assign V     = v_q;
   assign busy  = (state_q == StRun);
   assign done  = (state_q == StDone);

endmodule

// File: tb/tb_seq_adder_nbit.sv
// Bench for seq_adder_nbit: three instances (CHUNK 4, 1, 16) checked cycle by cycle
// against spec vectors and a plain-arithmetic reference model.
module tb_seq_adder_nbit;

   localparam int W = 16;

   logic          clk, rst_n, start, start_x, sub, c_in;
   logic [W-1:0]  a, b;
   logic [W-1:0]  s_o [3];
   logic          c_o [3];
   logic          v_o [3];
   logic          busy_o [3];
   logic          done_o [3];

   int n_tests = 0;
   int n_fail  = 0;

   seq_adder_nbit #(.WIDTH(W), .CHUNK(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(a), .B(b), .C_in(c_in),
      .S(s_o[0]), .C_out(c_o[0]), .V(v_o[0]), .busy(busy_o[0]), .done(done_o[0])
   );

   seq_adder_nbit #(.WIDTH(W), .CHUNK(1)) u_dut_c1 (
      .clk(clk), .rst_n(rst_n), .start(start_x), .sub(sub), .A(a), .B(b), .C_in(c_in),
      .S(s_o[1]), .C_out(c_o[1]), .V(v_o[1]), .busy(busy_o[1]), .done(done_o[1])
   );

   seq_adder_nbit #(.WIDTH(W), .CHUNK(16)) u_dut_c16 (
      .clk(clk), .rst_n(rst_n), .start(start_x), .sub(sub), .A(a), .B(b), .C_in(c_in),
      .S(s_o[2]), .C_out(c_o[2]), .V(v_o[2]), .busy(busy_o[2]), .done(done_o[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic         cin;
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } vec_t;

   function automatic int cw_of(input int i);
      return (i == 0) ? 4 : (i == 1) ? 1 : 16;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                        input logic mcin, output logic [W-1:0] es, output logic ec,
                        output logic ev);
      int sa, sb, r, full;
      sa = $signed(ma);
      sb = $signed(mb);
      if (msub) begin
         es = ma - mb;
         ec = (ma >= mb);
         r  = sa - sb;
      end else begin
         full = int'(ma) + int'(mb) + int'(mcin);
         es   = full[W-1:0];
         ec   = (full > 65535);
         r    = sa + sb + int'(mcin);
      end
      ev = (r > 32767) || (r < -32768);
   endtask

   // Start one operation on all three instances and check every output for 20 cycles.
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tsub, input logic tcin, input logic [W-1:0] es,
                         input logic ec, input logic ev);
      int n, bits;
      logic [W-1:0] m;
      a = ta; b = tb; sub = tsub; c_in = tcin;
      start = 1'b1; start_x = 1'b1;
      tick();
      start = 1'b0; start_x = 1'b0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         for (int i = 0; i < 3; i++) begin
            n    = W / cw_of(i);
            bits = (cyc - 1) * cw_of(i);
            if (bits >= W) m = '1;
            else m = W'((32'd1 << bits) - 1);
            chk($sformatf("%s d%0d cyc%0d S", tag, i, cyc), 32'(s_o[i]), 32'(es & m));
            chk($sformatf("%s d%0d cyc%0d busy", tag, i, cyc), 32'(busy_o[i]), 32'(cyc <= n));
            chk($sformatf("%s d%0d cyc%0d done", tag, i, cyc), 32'(done_o[i]),
                32'(cyc == n + 1));
            chk($sformatf("%s d%0d cyc%0d C_out", tag, i, cyc), 32'(c_o[i]),
                32'((cyc >= n + 1) ? ec : 1'b0));
            chk($sformatf("%s d%0d cyc%0d V", tag, i, cyc), 32'(v_o[i]),
                32'((cyc >= n + 1) ? ev : 1'b0));
         end
         if (cyc < 20) tick();
      end
   endtask

   vec_t vecs [6];

   initial begin
      logic [W-1:0] ra, rb, es;
      logic         rs, rc, ec, ev;

      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
      vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};

      // Reset held with start high.
      rst_n = 1'b0; start = 1'b1; start_x = 1'b1;
      a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; c_in = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst d%0d S", i), 32'(s_o[i]), 32'h0);
         chk($sformatf("rst d%0d C_out", i), 32'(c_o[i]), 32'h0);
         chk($sformatf("rst d%0d V", i), 32'(v_o[i]), 32'h0);
         chk($sformatf("rst d%0d busy", i), 32'(busy_o[i]), 32'h0);
         chk($sformatf("rst d%0d done", i), 32'(done_o[i]), 32'h0);
      end
      rst_n = 1'b1; start = 1'b0; start_x = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         for (int i = 0; i < 3; i++)
            chk($sformatf("post-rst d%0d busy", i), 32'(busy_o[i]), 32'h0);
      end

      for (int k = 0; k < 6; k++)
         run_op($sformatf("vec%0d", k), vecs[k].a, vecs[k].b, vecs[k].sub, vecs[k].cin,
                vecs[k].s, vecs[k].c, vecs[k].v);

      // start during RUN ignored; start in DONE accepted back-to-back.
      a = 16'h1234; b = 16'h4321; sub = 1'b0; c_in = 1'b0; start = 1'b1;
      tick();                                   // cycle 1
      start = 1'b0;
      tick();                                   // cycle 2
      start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1;
      tick();                                   // cycle 3
      start = 1'b0;
      chk("hs busy c3", 32'(busy_o[0]), 32'h1);
      tick();
      tick();                                   // cycle 5
      chk("hs done c5", 32'(done_o[0]), 32'h1);
      chk("hs S c5", 32'(s_o[0]), 32'h5555);
      chk("hs C c5", 32'(c_o[0]), 32'h0);
      a = 16'h7FFF; b = 16'h0001; c_in = 1'b0; start = 1'b1;
      tick();                                   // next op cycle 1
      start = 1'b0;
      chk("b2b busy c1", 32'(busy_o[0]), 32'h1);
      chk("b2b done c1", 32'(done_o[0]), 32'h0);
      chk("b2b S c1", 32'(s_o[0]), 32'h0);
      for (int k = 2; k <= 4; k++) begin
         tick();
         chk($sformatf("b2b busy c%0d", k), 32'(busy_o[0]), 32'h1);
         chk($sformatf("b2b done c%0d", k), 32'(done_o[0]), 32'h0);
      end
      tick();                                   // cycle 5
      chk("b2b done c5", 32'(done_o[0]), 32'h1);
      chk("b2b S c5", 32'(s_o[0]), 32'h8000);
      chk("b2b V c5", 32'(v_o[0]), 32'h1);
      chk("b2b C c5", 32'(c_o[0]), 32'h0);
      tick();
      chk("b2b done c6", 32'(done_o[0]), 32'h0);
      chk("b2b S held", 32'(s_o[0]), 32'h8000);

      // Reset in the middle of a RUN.
      a = 16'h1234; b = 16'h4321; start = 1'b1;
      tick();                                   // cycle 1
      start = 1'b0;
      tick();                                   // cycle 2
      rst_n = 1'b0;
      tick();                                   // cycle 3
      chk("midrst busy", 32'(busy_o[0]), 32'h0);
      chk("midrst S", 32'(s_o[0]), 32'h0);
      chk("midrst done", 32'(done_o[0]), 32'h0);
      chk("midrst V", 32'(v_o[0]), 32'h0);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("midrst done +%0d", k), 32'(done_o[0]), 32'h0);
         chk($sformatf("midrst busy +%0d", k), 32'(busy_o[0]), 32'h0);
      end

      for (int k = 0; k < 40; k++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rs = 1'($urandom);
         rc = 1'($urandom);
         if (k < 4) begin
            ra = (k[0]) ? 16'h8000 : 16'h7FFF;
            rb = (k[1]) ? 16'hFFFF : 16'h8000;
         end
         model(ra, rb, rs, rc, es, ec, ev);
         run_op($sformatf("rnd%0d", k), ra, rb, rs, rc, es, ec, ev);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
